uart_line_assembler: RTL and testbench

Sits between the UART receiver (byte + one-cycle done pulse) and the UART transmitter (byte + one-cycle start pulse) on the DE0-Nano/HC-05 link. It collects received bytes into a line buffer and applies backspace editing. On end-of-line it replays the edited line to the transmitter, followed by CR LF. This replaces byte-by-byte echo with line-oriented echo, the basis for a later command parser.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/line_buf_ram.sv | 22 ++
 rtl/uart_line_assembler.sv | 170 +++++++++++++++++
 tb/tb_uart_line_assembler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART line assembler.
// Sits between the UART receiver and transmitter.
package uart_pkg;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_DEL = 8'h7F;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_SEND,
    ST_WAIT,
    ST_EOL_CR,
    ST_EOL_LF
  } line_state_t;

  function automatic logic is_erase(input logic [7:0] b);
    return (b == ASCII_BS) || (b == ASCII_DEL);
  endfunction

endpackage

// File: rtl/line_buf_ram.sv
// Simple dual-port line buffer with a registered read port.
// Written in the plain form that maps onto block RAM; it holds no control logic.
module line_buf_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_line_assembler.sv
// Collects received bytes into an editable line buffer.
// On end-of-line it replays the line to the transmitter, followed by CR LF.
//
// state      | meaning
// COLLECT    | accepting bytes, applying backspace editing
// SEND       | waiting for an idle transmitter to issue buffered byte idx
// WAIT       | transmit handshake in flight; ret_q records the issuing state
// EOL_CR     | waiting for an idle transmitter to issue CR
// EOL_LF     | waiting for an idle transmitter to issue LF
module uart_line_assembler
  import uart_pkg::*;
#(
  parameter int         DEPTH    = 32,
  parameter int         ADDR_W   = 5,
  parameter logic [7:0] EOL_CHAR = 8'h0D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              line_ready,
  output logic [ADDR_W:0]   line_len,
  output logic              overflow
);

  localparam logic [ADDR_W:0]   FULL       = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_CNT    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_IDX    = ADDR_W'(1);
  localparam logic [1:0]        GUARD_LOAD = 2'd2;

  line_state_t       state_q, state_d;
  line_state_t       ret_q, ret_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        guard_q, guard_d;
  logic              ovf_q, ovf_d;
  logic              start_q, start_d;
  logic              ready_q, ready_d;
  logic [7:0]        txd_q, txd_d;
  logic              we;
  logic [7:0]        rd_data;

  // Read address follows the next idx so the byte is already on rd_data
  // in the cycle SEND decides to issue it.
  line_buf_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .we      (we),
    .wr_addr (count_q[ADDR_W-1:0]),
    .wr_data (rx_data),
    .rd_addr (idx_d),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      ret_q   <= ST_COLLECT;
      count_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      guard_q <= '0;
      ovf_q   <= 1'b0;
      start_q <= 1'b0;
      ready_q <= 1'b0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      count_q <= count_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      guard_q <= guard_d;
      ovf_q   <= ovf_d;
      start_q <= start_d;
      ready_q <= ready_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    count_d = count_q;
    len_d   = len_q;
    idx_d   = idx_q;
    guard_d = guard_q;
    ovf_d   = ovf_q;
    start_d = 1'b0;
    ready_d = 1'b0;
    txd_d   = txd_q;
    we      = 1'b0;

    // Bytes arriving while the line is being echoed are lost.
    if (rx_valid && (state_q != ST_COLLECT)) ovf_d = 1'b1;

    case (state_q)
      ST_COLLECT: begin
        if (rx_valid) begin
          if (rx_data == EOL_CHAR) begin
            len_d   = count_q;
            ready_d = 1'b1;
            idx_d   = '0;
            state_d = (count_q == '0) ? ST_EOL_CR : ST_SEND;
          end else if (is_erase(rx_data)) begin
            if (count_q != '0) count_d = count_q - ONE_CNT;
          end else if (count_q < FULL) begin
            we      = 1'b1;
            count_d = count_q + ONE_CNT;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end

      ST_SEND, ST_EOL_CR, ST_EOL_LF: begin
        if (!tx_busy) begin
          start_d = 1'b1;
          case (state_q)
            ST_SEND:   txd_d = rd_data;
            ST_EOL_CR: txd_d = ASCII_CR;
            default:   txd_d = ASCII_LF;
          endcase
          ret_d   = state_q;
          guard_d = GUARD_LOAD;
          state_d = ST_WAIT;
        end
      end

      // Start cycle and the guard cycle after it ignore tx_busy.
      ST_WAIT: begin
        if (guard_q != 2'd0) begin
          guard_d = guard_q - 2'd1;
        end else if (!tx_busy) begin
          case (ret_q)
            ST_SEND: begin
              if (({1'b0, idx_q} + ONE_CNT) < len_q) begin
                idx_d   = idx_q + ONE_IDX;
                state_d = ST_SEND;
              end else begin
                state_d = ST_EOL_CR;
              end
            end
            ST_EOL_CR: state_d = ST_EOL_LF;
            default: begin
              count_d = '0;
              ovf_d   = 1'b0;
              state_d = ST_COLLECT;
            end
          endcase
        end
      end

      default: state_d = ST_COLLECT;
    endcase
  end

  assign tx_data    = txd_q;
  assign tx_start   = start_q;
  assign line_ready = ready_q;
  assign line_len   = len_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_line_assembler.sv
// Randomized scoreboard bench for uart_line_assembler with a line-level
// reference model and a 10-cycle-per-byte transmitter model.
module tb_uart_line_assembler;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int TX_CYC = 10;
  localparam int BUDGET = 3000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_valid = 1'b0;
  logic            tx_busy;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            line_ready;
  logic [ADDR_W:0] line_len;
  logic            overflow;

  always #5 clk = ~clk;

  uart_line_assembler #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .EOL_CHAR (8'h0D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .line_ready (line_ready),
    .line_len   (line_len),
    .overflow   (overflow)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_starts = 0;
  int cyc = 0;
  int last_start = -100;
  int busy_cnt = 0;
  logic force_busy = 1'b0;

  logic [7:0] exp_tx[$];
  int         exp_len[$];
  logic       exp_ovf[$];
  logic [7:0] model_line[$];
  logic       model_ovf = 1'b0;

  assign tx_busy = force_busy || (busy_cnt != 0);

  // Transmitter model: busy for TX_CYC cycles starting the cycle after a start.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start) busy_cnt <= TX_CYC;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) begin
        n_starts++;
        check("start_while_busy", {31'd0, tx_busy}, 32'd0);
        n_chk++;
        if (cyc - last_start < 3) begin
          n_fail++;
          $display("FAIL start_spacing got=%0d required>=3", cyc - last_start);
        end
        last_start = cyc;
        n_chk++;
        if (exp_tx.size() == 0) begin
          n_fail++;
          $display("FAIL tx_unexpected got=%02h required=none", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_tx.pop_front();
          if (tx_data !== e) begin
            n_fail++;
            $display("FAIL tx_data got=%02h required=%02h", tx_data, e);
          end
        end
      end
      if (line_ready) begin
        n_chk++;
        if (exp_len.size() == 0) begin
          n_fail++;
          $display("FAIL line_ready_unexpected got=1 required=0");
        end else begin
          int   el;
          logic eo;
          el = exp_len.pop_front();
          eo = exp_ovf.pop_front();
          if (line_len !== (ADDR_W+1)'(el)) begin
            n_fail++;
            $display("FAIL line_len got=%0d required=%0d", line_len, el);
          end
          check("overflow_at_eol", {31'd0, overflow}, {31'd0, eo});
        end
      end
    end
  end

  // Reference model: line semantics computed directly on a queue of bytes.
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'h0D) begin
      foreach (model_line[i]) exp_tx.push_back(model_line[i]);
      exp_tx.push_back(8'h0D);
      exp_tx.push_back(8'h0A);
      exp_len.push_back(model_line.size());
      exp_ovf.push_back(model_ovf);
      model_line.delete();
      model_ovf = 1'b0;
    end else if (b == 8'h08 || b == 8'h7F) begin
      if (model_line.size() > 0) void'(model_line.pop_back());
    end else if (model_line.size() < DEPTH) begin
      model_line.push_back(b);
    end else begin
      model_ovf = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit modeled);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    if (modeled) model_byte(b);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_tx.size() != 0 || tx_busy) && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (t >= BUDGET) begin
      n_fail++;
      $display("FAIL line_timeout got=%0d pending required=0", exp_tx.size());
      exp_tx.delete();
      exp_len.delete();
      exp_ovf.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_starts(input int target);
    int t;
    t = 0;
    while (n_starts < target && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (t >= BUDGET) begin
      n_fail++;
      $display("FAIL start_timeout got=%0d required=%0d", n_starts, target);
    end
  endtask

  initial begin
    int         s0;
    int         s1;
    int         n;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    check("reset_outputs", {19'd0, tx_start, tx_data, line_ready, (ADDR_W+1)'(line_len), overflow}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send_str("AB"); send_byte(8'h0D, 1'b1); wait_done();
    send_str("AX"); send_byte(8'h08, 1'b1); send_str("B"); send_byte(8'h0D, 1'b1); wait_done();
    send_byte(8'h08, 1'b1); send_byte(8'h7F, 1'b1); send_str("C"); send_byte(8'h0D, 1'b1); wait_done();

    send_str("ABCDEFGHIJK"); send_byte(8'h0D, 1'b1); wait_done();
    check("overflow_cleared_after_lf", {31'd0, overflow}, 32'd0);

    send_byte(8'h0D, 1'b1); wait_done();

    s0 = n_starts;
    send_str("MNOP"); send_byte(8'h0D, 1'b1);
    wait_starts(s0 + 1);
    send_byte("Q", 1'b0);
    check("overflow_rx_during_send", {31'd0, overflow}, 32'd1);
    wait_done();
    check("overflow_clear_after_send_drop", {31'd0, overflow}, 32'd0);

    s0 = n_starts;
    send_str("HI"); send_byte(8'h0D, 1'b1);
    wait_starts(s0 + 1);
    force_busy = 1'b1;
    s1 = n_starts;
    repeat (200) @(negedge clk);
    check("no_start_while_held_busy", n_starts, s1);
    force_busy = 1'b0;
    wait_done();

    for (int l = 0; l < 15; l++) begin
      n = $urandom_range(0, 11);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 6) == 0) b = ($urandom_range(0, 1) != 0) ? 8'h08 : 8'h7F;
        else b = 8'($urandom_range(32, 126));
        send_byte(b, 1'b1);
      end
      send_byte(8'h0D, 1'b1);
      wait_done();
      check("overflow_idle_after_line", {31'd0, overflow}, 32'd0);
    end

    s0 = n_starts;
    send_str("VWXYZ"); send_byte(8'h0D, 1'b1);
    wait_starts(s0 + 1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_line_reset_outputs", {19'd0, tx_start, tx_data, line_ready, (ADDR_W+1)'(line_len), overflow}, 32'd0);
    exp_tx.delete();
    exp_len.delete();
    exp_ovf.delete();
    model_line.delete();
    model_ovf = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_str("Z"); send_byte(8'h0D, 1'b1); wait_done();
    check("scoreboard_drained", exp_tx.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
